// File: rtl/mapper_reg_pkg.sv
// Shared constants and types for the mapper register controller: register
// indices, control-byte bit positions, write-filter states and reset values.
package mapper_reg_pkg;

  localparam logic [1:0] REG_PRG    = 2'b00;
  localparam logic [1:0] REG_CTRL   = 2'b01;
  localparam logic [1:0] REG_LATCH  = 2'b10;
  localparam logic [1:0] REG_RELOAD = 2'b11;

  localparam int CTRL_MIRROR = 0;
  localparam int CTRL_IRQ_EN = 1;

  typedef enum logic {
    WF_IDLE,
    WF_SEEN
  } wf_state_e;

  localparam int unsigned RST_PRG_BANK = 0;
  localparam int unsigned RST_LATCH    = 0;
  localparam int unsigned RST_COUNTER  = 0;
  localparam logic        RST_MIRROR   = 1'b0;
  localparam logic        RST_IRQ_EN   = 1'b0;
  localparam logic        RST_PENDING  = 1'b0;

  // A CPU cycle that writes into the $8000-$FFFF ROM window.
  function automatic logic is_rom_write(input logic romsel, input logic cpu_rw);
    return (!romsel) && (!cpu_rw);
  endfunction

endpackage

// File: rtl/mapper_reg_ctrl_if.sv
// CPU bus pins seen by the mapper register controller, sampled on M2 rising edges.
interface mapper_reg_ctrl_if;
  logic        romsel;
  logic        cpu_rw_in;
  logic [14:0] cpu_addr_in;
  logic [7:0]  cpu_data_in;

  modport master (
    output romsel,
    output cpu_rw_in,
    output cpu_addr_in,
    output cpu_data_in
  );

  modport slave (
    input romsel,
    input cpu_rw_in,
    input cpu_addr_in,
    input cpu_data_in
  );
endinterface

// File: rtl/mapper_reg_ctrl_irq_counter.sv
// CPU-cycle IRQ down-counter with reload latch, enable and sticky pending flag.
// Zero with the enable set raises pending and reloads, so the count never wraps.
module cpu_cycle_irq_counter
  import mapper_reg_pkg::*;
#(
  parameter int IRQ_BITS = 16
) (
  input  logic       clk,
  input  logic       srst_n,
  input  logic       latch_lo_we,
  input  logic       latch_hi_we,
  input  logic       reload,
  input  logic       ctrl_we,
  input  logic [7:0] data,
  output logic       pending
);

  logic [IRQ_BITS-1:0] latch_q, latch_d;
  logic [IRQ_BITS-1:0] counter_q, counter_d;
  logic                irq_en_q, irq_en_d;
  logic                pending_q, pending_d;

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      latch_q   <= IRQ_BITS'(RST_LATCH);
      counter_q <= IRQ_BITS'(RST_COUNTER);
      irq_en_q  <= RST_IRQ_EN;
      pending_q <= RST_PENDING;
    end else begin
      latch_q   <= latch_d;
      counter_q <= counter_d;
      irq_en_q  <= irq_en_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    latch_d   = latch_q;
    counter_d = counter_q;
    irq_en_d  = irq_en_q;
    pending_d = pending_q;

    if (latch_lo_we) latch_d[7:0] = data;
    if (latch_hi_we) latch_d[IRQ_BITS-1:8] = data[IRQ_BITS-9:0];
    if (ctrl_we)     irq_en_d = data[CTRL_IRQ_EN];

    // Reload and count both read latch_q, so a same-edge latch write is not seen yet.
    if (reload) begin
      counter_d = latch_q;
      pending_d = 1'b0;
    end else if (irq_en_q) begin
      if (counter_q == '0) begin
        pending_d = 1'b1;
        counter_d = latch_q;
      end else begin
        counter_d = counter_q - IRQ_BITS'(1);
      end
    end

    // Disabling acknowledges, even against a same-edge expiry.
    if (ctrl_we && !data[CTRL_IRQ_EN]) pending_d = 1'b0;
  end

  assign pending = pending_q;

endmodule

// File: rtl/mapper_reg_ctrl.sv
// Mapper register controller: filters RMW double writes, decodes $8000-$FFFF
// writes into PRG bank / mirroring / IRQ registers, and drives the IRQ request.
module mapper_reg_ctrl
  import mapper_reg_pkg::*;
#(
  parameter int PRG_BITS = 4,
  parameter int IRQ_BITS = 16
) (
  input  logic                m2,
  input  logic                reset_n,
  mapper_reg_ctrl_if.slave    bus,
  output logic [PRG_BITS-1:0] prg_bank,
  output logic                ciram_a10,
  output logic                irq_n
);

  wf_state_e           wf_q, wf_d;
  logic [PRG_BITS-1:0] prg_bank_q, prg_bank_d;
  logic                mirror_q, mirror_d;

  logic       rwc;
  logic       accept;
  logic [1:0] reg_idx;
  logic       prg_we, ctrl_we, latch_lo_we, latch_hi_we, reload_we;
  logic       pending;
  logic       unused_addr;

  assign rwc         = is_rom_write(bus.romsel, bus.cpu_rw_in);
  assign accept      = rwc && (wf_q == WF_IDLE);
  assign reg_idx     = bus.cpu_addr_in[14:13];
  assign unused_addr = ^bus.cpu_addr_in[12:1];

  assign prg_we      = accept && (reg_idx == REG_PRG);
  assign ctrl_we     = accept && (reg_idx == REG_CTRL);
  assign latch_lo_we = accept && (reg_idx == REG_LATCH) && !bus.cpu_addr_in[0];
  assign latch_hi_we = accept && (reg_idx == REG_LATCH) &&  bus.cpu_addr_in[0];
  assign reload_we   = accept && (reg_idx == REG_RELOAD);

  always_ff @(posedge m2) begin
    if (!reset_n) begin
      wf_q       <= WF_IDLE;
      prg_bank_q <= PRG_BITS'(RST_PRG_BANK);
      mirror_q   <= RST_MIRROR;
    end else begin
      wf_q       <= wf_d;
      prg_bank_q <= prg_bank_d;
      mirror_q   <= mirror_d;
    end
  end

  // The dummy write of an RMW and its real write arrive back to back; only the first commits.
  always_comb begin
    wf_d = wf_q;
    case (wf_q)
      WF_IDLE: if (rwc)  wf_d = WF_SEEN;
      WF_SEEN: if (!rwc) wf_d = WF_IDLE;
      default: wf_d = WF_IDLE;
    endcase
  end

  always_comb begin
    prg_bank_d = prg_bank_q;
    mirror_d   = mirror_q;
    if (prg_we)  prg_bank_d = bus.cpu_data_in[PRG_BITS-1:0];
    if (ctrl_we) mirror_d   = bus.cpu_data_in[CTRL_MIRROR];
  end

  cpu_cycle_irq_counter #(
    .IRQ_BITS (IRQ_BITS)
  ) u_irq_counter (
    .clk         (m2),
    .srst_n      (reset_n),
    .latch_lo_we (latch_lo_we),
    .latch_hi_we (latch_hi_we),
    .reload      (reload_we),
    .ctrl_we     (ctrl_we),
    .data        (bus.cpu_data_in),
    .pending     (pending)
  );

  assign prg_bank  = prg_bank_q;
  assign ciram_a10 = mirror_q;
  assign irq_n     = ~pending;

endmodule
